// File: rtl/aes_axis_blk_collector_if.sv
// Stream and block-handshake bundle for the AES ingress collector.
// The collector is the stream slave and the block-side source; the
// master modport is the host/DMA plus AES-core side of the bundle.
interface aes_axis_blk_collector_if;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic [0:127] out_blk;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        out_partial;

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    input  s_axis_tready,
    input  out_blk, out_valid, out_last, out_partial,
    output out_ready
  );

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    output s_axis_tready,
    output out_blk, out_valid, out_last, out_partial,
    input  out_ready
  );
endinterface

// File: rtl/aes_axis_blk_collector.sv
// AES ingress collector: byte-swaps 32-bit stream words, packs four of
// them into a 128-bit block (first word at bit 0 of [0:127]), tags blocks
// closed early by tlast, and holds one finished block in an output
// register while the next block keeps assembling.
module aes_axis_blk_collector #(
  parameter bit SWAP_BYTES = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic             aclk,
  input  logic             aresetn,
  aes_axis_blk_collector_if.slave bus,
  output logic             frame_err,
  output logic [CNT_W-1:0] blk_cnt
);

  localparam int DATA_W = 32;
  localparam int BLK_W  = 128;

  function automatic logic [DATA_W-1:0] swap_word(input logic [DATA_W-1:0] w);
    return SWAP_BYTES ? {w[7:0], w[15:8], w[23:16], w[31:24]} : w;
  endfunction

  logic              aresetn_q;
  logic [1:0]        idx;
  logic [0:BLK_W-1]  asm_p0;
  logic [0:BLK_W-1]  asm_next;
  logic [0:BLK_W-1]  blk_p1;
  logic              vld_p1;
  logic              last_p1;
  logic              part_p1;
  logic              completing;
  logic              tready;
  logic              accept;
  logic              complete;
  logic              drain;
  logic              partial_now;

  // Handshake decode: stall only a word that would close a block while the
  // output register is full and not emptying this cycle.
  always_comb begin
    completing  = (idx == 2'd3) || bus.s_axis_tlast;
    tready      = aresetn_q && !(completing && vld_p1 && !bus.out_ready);
    accept      = bus.s_axis_tvalid && tready;
    complete    = accept && completing;
    drain       = vld_p1 && bus.out_ready;
    partial_now = bus.s_axis_tlast && (idx != 2'd3);
  end

  // Merge the incoming (optionally swapped) word into its slot of the block.
  always_comb begin
    asm_next = asm_p0;
    asm_next[{idx, 5'd0} +: DATA_W] = swap_word(bus.s_axis_tdata);
  end

  // Registered copy of reset keeps tready low for one cycle after release.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) aresetn_q <= 1'b0;
    else          aresetn_q <= 1'b1;
  end

  // ---- stage p0: word assembly ----
  // Fill words in order; a completing word clears the buffer for the next block.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      idx    <= 2'd0;
      asm_p0 <= '0;
    end else if (accept) begin
      if (completing) begin
        idx    <= 2'd0;
        asm_p0 <= '0;
      end else begin
        idx    <= idx + 2'd1;
        asm_p0 <= asm_next;
      end
    end
  end

  // ---- stage p1: output block register ----
  // Load on completion (even while draining the previous block); otherwise
  // drop valid once the consumer takes the block.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      blk_p1  <= '0;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      part_p1 <= 1'b0;
    end else if (complete) begin
      blk_p1  <= asm_next;
      vld_p1  <= 1'b1;
      last_p1 <= bus.s_axis_tlast;
      part_p1 <= partial_now;
    end else if (drain) begin
      vld_p1  <= 1'b0;
    end
  end

  // Status: sticky framing error and wrapping completed-block counter.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      frame_err <= 1'b0;
      blk_cnt   <= '0;
    end else if (complete) begin
      blk_cnt <= blk_cnt + CNT_W'(1);
      if (partial_now) frame_err <= 1'b1;
    end
  end

  assign bus.s_axis_tready = tready;
  assign bus.out_blk       = blk_p1;
  assign bus.out_valid     = vld_p1;
  assign bus.out_last      = last_p1;
  assign bus.out_partial   = part_p1;

endmodule

// File: tb/tb_aes_axis_blk_collector.sv
// Bench for aes_axis_blk_collector: two instances (swap on / 16-bit count,
// swap off / 2-bit count) share one stimulus; a word-list scoreboard model
// predicts blocks, flags, counters and ready every cycle.
module tb_aes_axis_blk_collector;

  logic        clk;
  logic        aresetn;
  logic        ferr0, ferr1;
  logic [15:0] cnt0;
  logic [1:0]  cnt1;

  aes_axis_blk_collector_if s0();
  aes_axis_blk_collector_if s1();

  aes_axis_blk_collector #(.SWAP_BYTES(1'b1), .CNT_W(16)) dut0 (
    .aclk(clk), .aresetn(aresetn), .bus(s0), .frame_err(ferr0), .blk_cnt(cnt0)
  );
  aes_axis_blk_collector #(.SWAP_BYTES(1'b0), .CNT_W(2)) dut1 (
    .aclk(clk), .aresetn(aresetn), .bus(s1), .frame_err(ferr1), .blk_cnt(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] sw;
    logic [127:0] raw;
    logic         last;
    logic         part;
  } blk_t;

  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] m_words[$];
  blk_t        exp_q[$];
  int          m_cnt;
  logic        m_ferr;
  logic        m_arq;
  logic        last_acc;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  task automatic drive(input logic v, input logic [31:0] d, input logic l, input logic r);
    s0.s_axis_tvalid = v; s0.s_axis_tdata = d; s0.s_axis_tlast = l; s0.out_ready = r;
    s1.s_axis_tvalid = v; s1.s_axis_tdata = d; s1.s_axis_tlast = l; s1.out_ready = r;
  endtask

  task automatic check_state(input logic l, input logic r);
    logic ev, er;
    ev = (exp_q.size() > 0);
    er = m_arq && !((m_words.size() == 3 || l) && ev && !r);
    chk("valid0", 128'(s0.out_valid), 128'(ev));
    chk("valid1", 128'(s1.out_valid), 128'(ev));
    if (ev) begin
      chk("blk0", 128'(s0.out_blk), exp_q[0].sw);
      chk("blk1", 128'(s1.out_blk), exp_q[0].raw);
      chk("last0", 128'(s0.out_last), 128'(exp_q[0].last));
      chk("part0", 128'(s0.out_partial), 128'(exp_q[0].part));
      chk("part1", 128'(s1.out_partial), 128'(exp_q[0].part));
    end
    chk("ferr0", 128'(ferr0), 128'(m_ferr));
    chk("ferr1", 128'(ferr1), 128'(m_ferr));
    chk("cnt0", 128'(cnt0), 128'(m_cnt % 65536));
    chk("cnt1", 128'(cnt1), 128'(m_cnt % 4));
    chk("tready0", 128'(s0.s_axis_tready), 128'(er));
    chk("tready1", 128'(s1.s_axis_tready), 128'(er));
  endtask

  // One clock cycle: drive, check against the model, then advance the model.
  task automatic cycle(input logic v, input logic [31:0] d, input logic l, input logic r);
    logic acc, hs;
    blk_t e;
    @(negedge clk);
    drive(v, d, l, r);
    #1;
    check_state(l, r);
    acc = v && s0.s_axis_tready;
    hs  = (exp_q.size() > 0) && r;
    @(posedge clk);
    last_acc = acc;
    if (hs) void'(exp_q.pop_front());
    if (acc) begin
      m_words.push_back(d);
      if (m_words.size() == 4 || l) begin
        e.sw = '0; e.raw = '0;
        foreach (m_words[i]) begin
          e.sw[127-32*i -: 32]  = bswap(m_words[i]);
          e.raw[127-32*i -: 32] = m_words[i];
        end
        e.last = l;
        e.part = (m_words.size() < 4);
        if (e.part) m_ferr = 1'b1;
        m_cnt++;
        exp_q.push_back(e);
        m_words.delete();
      end
    end
    m_arq = aresetn;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    aresetn = 1'b0;
    #1;
    chk("rst_blk0", 128'(s0.out_blk), 128'h0);
    chk("rst_valid0", 128'(s0.out_valid), 128'h0);
    chk("rst_last0", 128'(s0.out_last), 128'h0);
    chk("rst_part0", 128'(s0.out_partial), 128'h0);
    chk("rst_ferr0", 128'(ferr0), 128'h0);
    chk("rst_cnt0", 128'(cnt0), 128'h0);
    chk("rst_tready0", 128'(s0.s_axis_tready), 128'h0);
    chk("rst_blk1", 128'(s1.out_blk), 128'h0);
    chk("rst_cnt1", 128'(cnt1), 128'h0);
    m_words.delete();
    exp_q.delete();
    m_cnt = 0; m_ferr = 1'b0; m_arq = 1'b0;
    repeat (2) @(posedge clk);
    @(posedge clk);
    #1 aresetn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0]  bp[8];
    logic [127:0] held;
    logic [31:0]  pd;
    logic         pv, pl;
    int           k, cb;
    int           seq[5];
    seq = '{1, 2, 3, 0, 1};
    aresetn = 1'b0;
    m_cnt = 0; m_ferr = 1'b0; m_arq = 1'b0; last_acc = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    do_reset();

    // Full block with swap
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    cycle(1'b1, 32'h33221100, 1'b0, 1'b1);
    cycle(1'b1, 32'h77665544, 1'b0, 1'b1);
    cycle(1'b1, 32'hBBAA9988, 1'b0, 1'b1);
    cycle(1'b1, 32'hFFEEDDCC, 1'b1, 1'b1);
    #2;
    chk("full_blk", 128'(s0.out_blk), 128'h00112233_44556677_8899AABB_CCDDEEFF);
    chk("full_valid", 128'(s0.out_valid), 128'h1);
    chk("full_last", 128'(s0.out_last), 128'h1);
    chk("full_part", 128'(s0.out_partial), 128'h0);
    chk("full_cnt", 128'(cnt0), 128'h1);
    chk("full_ferr", 128'(ferr0), 128'h0);

    // Partial block
    cycle(1'b1, 32'h03020100, 1'b0, 1'b1);
    cycle(1'b1, 32'h07060504, 1'b1, 1'b1);
    #2;
    chk("part_blk", 128'(s0.out_blk), 128'h00010203_04050607_00000000_00000000);
    chk("part_flag", 128'(s0.out_partial), 128'h1);
    chk("part_last", 128'(s0.out_last), 128'h1);
    chk("part_ferr", 128'(ferr0), 128'h1);
    for (int i = 0; i < 4; i++) cycle(1'b1, $urandom, 1'b0, 1'b1);
    #2;
    chk("ferr_sticky", 128'(ferr0), 128'h1);
    chk("good_part", 128'(s0.out_partial), 128'h0);
    cycle(1'b0, 32'h0, 1'b0, 1'b1);

    // Back-pressure: out_ready low for 12 cycles
    for (int i = 0; i < 8; i++) bp[i] = $urandom;
    k = 0;
    held = '0;
    for (int c = 0; c < 40 && k < 8; c++) begin
      cycle(1'b1, bp[k], 1'b0, c >= 12);
      if (last_acc) k++;
      #2;
      if (c == 4) held = 128'(s0.out_blk);
      if (c == 11) begin
        chk("bp_accepted", 128'(k), 128'd7);
        chk("bp_stable", 128'(s0.out_blk), held);
      end
    end
    chk("bp_all_sent", 128'(k), 128'd8);
    repeat (3) cycle(1'b0, 32'h0, 1'b0, 1'b1);

    // Simultaneous drain and complete
    for (int i = 0; i < 4; i++) cycle(1'b1, $urandom, 1'b0, 1'b0);
    cycle(1'b1, 32'h10111213, 1'b0, 1'b0);
    cycle(1'b1, 32'h14151617, 1'b0, 1'b0);
    cycle(1'b1, 32'h18191A1B, 1'b0, 1'b0);
    cb = int'(cnt0);
    cycle(1'b1, 32'h1C1D1E1F, 1'b0, 1'b1);
    #2;
    chk("sim_valid", 128'(s0.out_valid), 128'h1);
    chk("sim_blk", 128'(s0.out_blk), 128'h13121110_17161514_1B1A1918_1F1E1D1C);
    chk("sim_cnt", 128'(cnt0), 128'(cb + 1));
    repeat (2) cycle(1'b0, 32'h0, 1'b0, 1'b1);

    // Reset mid-block
    for (int i = 0; i < 3; i++) cycle(1'b1, $urandom, 1'b0, 1'b1);
    do_reset();
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    cycle(1'b1, 32'hA0A1A2A3, 1'b0, 1'b1);
    cycle(1'b1, 32'hB0B1B2B3, 1'b0, 1'b1);
    cycle(1'b1, 32'hC0C1C2C3, 1'b0, 1'b1);
    cycle(1'b1, 32'hD0D1D2D3, 1'b0, 1'b1);
    #2;
    chk("rmid_blk", 128'(s0.out_blk), 128'hA3A2A1A0_B3B2B1B0_C3C2C1C0_D3D2D1D0);
    chk("rmid_cnt", 128'(cnt0), 128'h1);
    chk("rmid_ferr", 128'(ferr0), 128'h0);
    repeat (2) cycle(1'b0, 32'h0, 1'b0, 1'b1);

    // Counter wrap on the 2-bit instance, unswapped first word
    do_reset();
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    for (int b = 0; b < 5; b++) begin
      for (int w = 0; w < 4; w++)
        cycle(1'b1, (b == 0 && w == 0) ? 32'h00112233 : $urandom, 1'b0, 1'b1);
      #2;
      chk($sformatf("wrap_cnt%0d", b), 128'(cnt1), 128'(seq[b]));
      if (b == 0) begin
        chk("noswap_w0", 128'(s1.out_blk[0:31]), 128'h00112233);
        chk("swap_w0", 128'(s0.out_blk[0:31]), 128'h33221100);
      end
    end

    // Randomized traffic; stalled words are held stable
    pv = 1'b0; pd = '0; pl = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (!(pv && !last_acc) || c == 0) begin
        pv = ($urandom_range(0, 3) != 0);
        pd = $urandom;
        pl = ($urandom_range(0, 5) == 0);
      end
      cycle(pv, pd, pl, $urandom_range(0, 4) < 3);
    end
    repeat (3) cycle(1'b0, 32'h0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/aes_axis_blk_collector.md
# aes_axis_blk_collector

Ingress stage that sits directly upstream of the AES core. It accepts the 32-bit AXI4-Stream words sent by the host/DMA and byte-swaps each word to undo the kernel's little-endian word packing. It assembles every four words into one 128-bit block, tags partial or terminating blocks, and hands blocks to the core over a valid/ready block interface. It is double-buffered, so the stream keeps flowing while the core holds a block.

## Interface
- SWAP_BYTES, 1, 1: reverse byte order inside each 32-bit word before packing; 0: pass words unmodified
- CNT_W, 16, width of the accepted-block counter
- aclk  in  1  clock; all logic on rising edge
- aresetn  in  1  asynchronous, active-low reset
- s_axis_tdata  in  32  stream word
- s_axis_tvalid  in  1  word valid
- s_axis_tready  out  1  word accepted when tvalid && tready
- s_axis_tlast  in  1  last word of packet
- out_blk  out  128  assembled block, bit [0:31] = first word of block (big-endian [0:127] indexing)
- out_valid  out  1  out_blk/out_last/out_partial valid
- out_ready  in  1  downstream accepts block when out_valid && out_ready
- out_last  out  1  block closed by tlast
- out_partial  out  1  block closed by tlast before 4 words; missing words are zero
- frame_err  out  1  sticky: set on any partial block; cleared only by reset
- blk_cnt  out  CNT_W  blocks transferred to the output register, wraps modulo 2^CNT_W

## Operation
- Word transform: w' = SWAP_BYTES ? {w[7:0],w[15:8],w[23:16],w[31:24]} : w.
- Word index register idx (0..3). An accepted word goes to asm[idx*32 +: 32] in [0:127] order, i.e. word 0 fills the MSB end.
- Block completes on an accepted word when idx==3, or when tlast is set on the accepted word.
  - On completion, the assembled block moves to the output register: unfilled words are zero, out_last=tlast, out_partial=(tlast && idx!=3). idx returns to 0 and asm clears.
  - Otherwise idx increments.
- Output register holds (out_blk, out_last, out_partial, out_valid).
  - out_valid set on completion.
  - out_valid cleared on an out_valid && out_ready handshake, unless a new completion happens in the same cycle. In that case the output register loads the new block and out_valid stays 1.
- s_axis_tready = aresetn_q && !(completing_word_possible && out_valid && !out_ready).
  - completing_word_possible = (idx==3) || s_axis_tlast.
  - So: stall only when the incoming word would complete a block and the output register is occupied and not draining this cycle.
  - tready depends combinationally on tlast and out_ready; this is documented and permitted.
- aresetn_q is a one-flop registered copy of aresetn. It holds tready low for the first cycle after reset release.
- frame_err sets on a partial completion. blk_cnt increments on every completion, wrapping from 2^CNT_W-1 to 0.
- Stall rules:
  - The output register is never overwritten while out_valid && !out_ready.
  - asm words 0..2 continue to fill while the output is stalled.

## Timing
- Reset (aresetn low, asynchronous): idx=0, asm=0, out_blk=0, out_valid=0, out_last=0, out_partial=0, frame_err=0, blk_cnt=0, s_axis_tready=0.
- s_axis_tready is 1 from the second rising edge after aresetn deasserts.
- Latency: a completing word accepted at edge N gives out_valid=1 after edge N, valid throughout cycle N+1.
- Throughput: one word per cycle sustained with out_ready held 1; one block per 4 cycles.
- Handshake stability:
  - out_blk/out_last/out_partial do not change while out_valid && !out_ready.
  - The upstream master must hold tdata/tlast stable while tvalid && !tready; the block does not check this.
- Reset mid-block discards the partial asm contents and any pending output; no block is emitted.
- tlast on word index 3 gives out_last=1, out_partial=0, frame_err unchanged.

## Test plan
- Full block, SWAP_BYTES=1: words 0x33221100, 0x77665544, 0xBBAA9988, 0xFFEEDDCC (tlast on 4th), out_ready=1 -> one cycle after the 4th accept: out_blk=00112233_44556677_8899AABB_CCDDEEFF, out_last=1, out_partial=0, blk_cnt=1.
- Back-pressure: 8 words streamed continuously, out_ready=0 until cycle 12, then 1.
  - Required: words 5-7 accepted, word 8 stalls (tready=0), first block stable and unchanged until its handshake.
  - Second block appears the cycle after word 8 is accepted; no data lost or duplicated.
- Simultaneous drain and complete: out_valid=1, out_ready=1 in the same cycle as the 4th word of the next block -> out_valid stays 1 and out_blk switches to the new block next cycle; blk_cnt increments by 1.
- Partial block: 2 words 0x03020100, 0x07060504 with tlast on the 2nd -> out_blk=00010203_04050607_00000000_00000000, out_partial=1, out_last=1, frame_err=1 and stays 1 through later good blocks.
- Reset mid-block: assert aresetn after 3 words -> all outputs zero immediately, tready=0. After release, 4 fresh words produce exactly one block with only the new data.
- Counter wrap with CNT_W=2: 5 blocks -> blk_cnt sequence 1,2,3,0,1. With SWAP_BYTES=0, word 0x00112233 appears unswapped at out_blk[0:31].
